// File: rtl/cache_controller_pkg.sv
// Shared types and constants for the direct-mapped cache controller.
// Defines the ADDRESS layout (tag/index/byte-select), the controller state
// enum, the array geometry and a byte-select helper.
package CachePackage;

  localparam int NUM_LINES   = 256;
  localparam int BLOCK_BYTES = 4;
  localparam int TAG_W       = 6;
  localparam int INDEX_W     = 8;
  localparam int BSEL_W      = 2;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [BSEL_W-1:0]  byte_sel;
  } ADDRESS;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE,
    RESPOND
  } state_t;

  // Byte k of a block occupies bits [8k+7:8k].
  function automatic logic [7:0] select_byte(input logic [BLOCK_BYTES*8-1:0] blk,
                                             input logic [BSEL_W-1:0] sel);
    return blk[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Storage for the cache: per-line valid bit, tag and 4-byte data block.
// Ports: i_clk/i_rst_n; async read port (i_rd_index -> o_rd_valid/tag/block);
// sync write port: whole-block refill (i_blk_we) or single-byte update (i_byte_we).
module cache_line_array
  import CachePackage::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [INDEX_W-1:0]       i_rd_index,
  output logic                     o_rd_valid,
  output logic [TAG_W-1:0]         o_rd_tag,
  output logic [BLOCK_BYTES*8-1:0] o_rd_block,
  input  logic                     i_blk_we,
  input  logic                     i_byte_we,
  input  logic [INDEX_W-1:0]       i_wr_index,
  input  logic [TAG_W-1:0]         i_wr_tag,
  input  logic [BLOCK_BYTES*8-1:0] i_wr_block,
  input  logic [BSEL_W-1:0]        i_wr_byte_sel,
  input  logic [7:0]               i_wr_byte
);

  logic [NUM_LINES-1:0]     r_valid;
  logic [TAG_W-1:0]         r_tag  [NUM_LINES];
  logic [BLOCK_BYTES*8-1:0] r_data [NUM_LINES];

  // Only the valid bits are reset; tag and data contents are don't-care until valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_blk_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_blk_we) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_block;
    end else if (i_byte_we) begin
      r_data[i_wr_index][{i_wr_byte_sel, 3'b000} +: 8] <= i_wr_byte;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_block = r_data[i_rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller (256 x 4 B).
// Ports: processor side Address/READrWRITE/ReqValid/Data(inout)/STALL/HIT/MISS;
// memory side MemAddr/MemRead/MemWrite/MemWData/MemByte/MemRData/MemReady.
// Optional CACHE_STATS_EN adds saturating HitCount/MissCount (STAT_W bits).
module cache_controller
  import CachePackage::*;
#(
  parameter int STAT_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] Address,
  input  logic        READrWRITE,
  input  logic        ReqValid,
  inout  wire  [7:0]  Data,
  output logic        STALL,
  output logic        HIT,
  output logic        MISS,
  output logic [13:0] MemAddr,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [7:0]  MemWData,
  output logic [1:0]  MemByte,
  input  logic [31:0] MemRData,
  input  logic        MemReady
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0] HitCount,
  output logic [STAT_W-1:0] MissCount
`endif
);

  if (STAT_W < 1) begin : g_stat_w_check
    $error("STAT_W must be at least 1");
  end

  state_t      r_state;
  state_t      w_next;
  ADDRESS      r_addr;
  logic        r_read;
  logic [7:0]  r_wdata;

  logic        w_rd_valid;
  logic [5:0]  w_rd_tag;
  logic [31:0] w_rd_block;
  logic        w_hit;
  logic        w_blk_we;
  logic        w_byte_we;
  logic        w_drive;
  logic [7:0]  w_rd_byte;

  cache_line_array u_lines (
    .i_clk         (clock),
    .i_rst_n       (reset),
    .i_rd_index    (r_addr.index),
    .o_rd_valid    (w_rd_valid),
    .o_rd_tag      (w_rd_tag),
    .o_rd_block    (w_rd_block),
    .i_blk_we      (w_blk_we),
    .i_byte_we     (w_byte_we),
    .i_wr_index    (r_addr.index),
    .i_wr_tag      (r_addr.tag),
    .i_wr_block    (MemRData),
    .i_wr_byte_sel (r_addr.byte_sel),
    .i_wr_byte     (r_wdata)
  );

  assign w_hit     = w_rd_valid && (w_rd_tag == r_addr.tag);
  assign w_rd_byte = select_byte(w_rd_block, r_addr.byte_sel);

  // The request registers only load in IDLE, so they hold MemAddr/MemWData
  // stable for the whole memory handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && ReqValid) begin
        r_addr  <= Address;
        r_read  <= READrWRITE;
        r_wdata <= Data;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    STALL     = 1'b0;
    HIT       = 1'b0;
    MISS      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemAddr   = '0;
    MemByte   = '0;
    MemWData  = '0;
    w_blk_we  = 1'b0;
    w_byte_we = 1'b0;
    w_drive   = 1'b0;
    case (r_state)
      IDLE: begin
        if (ReqValid) w_next = LOOKUP;
      end
      LOOKUP: begin
        STALL = 1'b1;
        HIT   = w_hit;
        MISS  = !w_hit;
        if (!r_read)    w_next = WRITE;
        else if (w_hit) w_next = RESPOND;
        else            w_next = REFILL;
      end
      REFILL: begin
        STALL   = 1'b1;
        MemRead = 1'b1;
        MemAddr = {r_addr.tag, r_addr.index};
        if (MemReady) begin
          w_blk_we = 1'b1;
          w_next   = RESPOND;
        end
      end
      WRITE: begin
        STALL    = 1'b1;
        MemWrite = 1'b1;
        MemAddr  = {r_addr.tag, r_addr.index};
        MemByte  = r_addr.byte_sel;
        MemWData = r_wdata;
        // No allocate on a write miss: only a resident line is patched.
        if (MemReady) begin
          w_byte_we = w_hit;
          w_next    = IDLE;
        end
      end
      RESPOND: begin
        w_drive = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign Data = w_drive ? w_rd_byte : 8'bz;

`ifdef CACHE_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
  logic [STAT_W-1:0] r_hit_cnt;
  logic [STAT_W-1:0] r_miss_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (HIT && r_hit_cnt != {STAT_W{1'b1}})   r_hit_cnt  <= r_hit_cnt + STAT_ONE;
      if (MISS && r_miss_cnt != {STAT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + STAT_ONE;
    end
  end

  assign HitCount  = r_hit_cnt;
  assign MissCount = r_miss_cnt;
`endif

endmodule
